// File: rtl/if_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, HLT opcode default, opcode field
// position and the fetch FSM state type. Also used by decode/control.
package if_unit_pkg;

    localparam logic [15:0] NOP_INSTR      = 16'h0000;
    localparam logic [3:0]  HLT_OPCODE_DEF = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_PC = 2'd1,
        HALT    = 2'd2
    } if_state_t;

    function automatic logic [3:0] get_opcode(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/if_unit_if_id_reg.sv
// IF/ID pipeline register: captures instruction, PC+1 and valid on load,
// clears to a bubble on bubble, otherwise holds.
import if_unit_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic        valid_out
);

    // bubble wins over load so a flush can never be overridden
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            instr_out <= NOP_INSTR;
            pc_out    <= 16'h0000;
            valid_out <= 1'b0;
        end else if (load) begin
            instr_out <= instr_in;
            pc_out    <= pc_in;
            valid_out <= 1'b1;
        end
    end

endmodule

// File: rtl/if_unit.sv
// Instruction-fetch stage with IF/ID register, stall/redirect handling and HLT freeze.
// Optional IF_PERF_CNT_EN adds a saturating fetch-stall cycle counter.
import if_unit_pkg::*;

module if_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_hazard,
    input  logic        PC_hazard,
    input  logic        PC_update,
    input  logic [15:0] PC_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic        valid_out,
`ifdef IF_PERF_CNT_EN
    output logic [15:0] fetch_stall_cnt,
`endif
    output logic        halted
);

    if_state_t   state, state_next;
    logic [15:0] pc, pc_next, pc_plus1;
    logic        id_load, id_bubble, stall_cycle;

    assign imem_addr = pc;
    assign pc_plus1  = pc + 16'd1;

    // Priority: redirect > HALT freeze > data stall > control stall > HLT > fetch
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        id_load     = 1'b0;
        id_bubble   = 1'b0;
        stall_cycle = 1'b0;
        if (PC_update) begin
            pc_next    = PC_target;
            id_bubble  = 1'b1;
            state_next = RUN;
        end else if (state == HALT) begin
            id_bubble = 1'b1;
        end else if (data_hazard) begin
            stall_cycle = 1'b1;
        end else if (PC_hazard) begin
            id_bubble   = 1'b1;
            state_next  = WAIT_PC;
            stall_cycle = 1'b1;
        end else if (state == WAIT_PC) begin
            id_bubble = 1'b1;
        end else if (get_opcode(imem_instr) == HLT_OPCODE) begin
            id_load    = 1'b1;
            state_next = HALT;
        end else begin
            id_load = 1'b1;
            pc_next = pc_plus1;
        end
    end

    // halted trails the HALT state by one cycle so the HLT itself is seen valid first
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            halted <= (state == HALT) && !PC_update;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (id_load),
        .bubble    (id_bubble),
        .instr_in  (imem_instr),
        .pc_in     (pc_plus1),
        .instr_out (instr_out),
        .pc_out    (PC_out),
        .valid_out (valid_out)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_stall_cnt <= 16'h0000;
        end else if (stall_cycle && fetch_stall_cnt != 16'hFFFF) begin
            fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall_cycle;
`endif

endmodule

// File: tb/tb_if_unit.sv
// Directed self-checking bench for if_unit: fetch, stalls, redirects, HLT, wrap, reset.
// Instruction memory is a small combinational model defined here.
module tb_if_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_hazard;
    logic        PC_hazard;
    logic        PC_update;
    logic [15:0] PC_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic [15:0] instr_out;
    logic [15:0] PC_out;
    logic        valid_out;
    logic        halted;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_unit dut (
        .clk         (clk),
        .rst         (rst),
        .data_hazard (data_hazard),
        .PC_hazard   (PC_hazard),
        .PC_update   (PC_update),
        .PC_target   (PC_target),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .instr_out   (instr_out),
        .PC_out      (PC_out),
        .valid_out   (valid_out),
`ifdef IF_PERF_CNT_EN
        .fetch_stall_cnt (fetch_stall_cnt),
`endif
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Memory contents: a few fixed words, everything else 16'h1000 | addr[11:0]
    function automatic logic [15:0] imemModel(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0001: return 16'h2345;
            16'h000A: return 16'hF000;
            default:  return {4'h1, a[11:0]};
        endcase
    endfunction

    assign imem_instr = imemModel(imem_addr);

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic dh, input logic ph,
                                 input logic pu, input logic [15:0] tgt);
        rst         = r;
        data_hazard = dh;
        PC_hazard   = ph;
        PC_update   = pu;
        PC_target   = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic [15:0] ins,
                             input logic [15:0] pcv, input logic v);
        checkOutput({tag, ".instr"}, instr_out, ins);
        checkOutput({tag, ".pc"}, PC_out, pcv);
        checkOutput({tag, ".valid"}, {15'd0, valid_out}, {15'd0, v});
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkIfId("reset", 16'h0000, 16'h0000, 1'b0);
        checkOutput("reset.addr", imem_addr, 16'h0000);
        checkOutput("reset.halted", {15'd0, halted}, 16'h0000);
`ifdef IF_PERF_CNT_EN
        checkOutput("reset.cnt", fetch_stall_cnt, 16'h0000);
`endif

        // Straight-line fetch
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkIfId("fetch0", 16'h1234, 16'h0001, 1'b1);
        checkOutput("fetch0.addr", imem_addr, 16'h0001);
        tick();
        checkIfId("fetch1", 16'h2345, 16'h0002, 1'b1);
        for (int i = 2; i < 5; i++) tick();
        checkIfId("fetch4", 16'h1004, 16'h0005, 1'b1);
        checkOutput("fetch4.addr", imem_addr, 16'h0005);

        // Data stall for two cycles at PC 5
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkIfId("dstall", 16'h1004, 16'h0005, 1'b1);
            checkOutput("dstall.addr", imem_addr, 16'h0005);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkIfId("dresume", 16'h1005, 16'h0006, 1'b1);
        checkOutput("dresume.addr", imem_addr, 16'h0006);
        tick();
        tick();
        checkOutput("pre_call.addr", imem_addr, 16'h0008);

        // Control hazard for three cycles at PC 8, then redirect to 0x40
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkIfId("phaz", 16'h0000, 16'h0000, 1'b0);
            checkOutput("phaz.addr", imem_addr, 16'h0008);
        end
`ifdef IF_PERF_CNT_EN
        checkOutput("cnt.after_stalls", fetch_stall_cnt, 16'd5);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040);
        tick();
        checkOutput("call.addr", imem_addr, 16'h0040);
        checkOutput("call.valid", {15'd0, valid_out}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkIfId("call.target", 16'h1040, 16'h0041, 1'b1);

        // Redirect to 10 where HLT lives
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h000A);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkIfId("hlt", 16'hF000, 16'h000B, 1'b1);
        checkOutput("hlt.halted", {15'd0, halted}, 16'h0000);
        checkOutput("hlt.addr", imem_addr, 16'h000A);
        for (int i = 0; i < 20; i++) begin
            // stall requests must be ignored while halted
            applyStimulus(1'b0, i[0], i[1], 1'b0, 16'h0000);
            tick();
            checkOutput("halt.halted", {15'd0, halted}, 16'h0001);
            checkOutput("halt.valid", {15'd0, valid_out}, 16'h0000);
            checkOutput("halt.addr", imem_addr, 16'h000A);
        end
`ifdef IF_PERF_CNT_EN
        checkOutput("cnt.after_halt", fetch_stall_cnt, 16'd5);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0003);
        tick();
        checkOutput("unhalt.halted", {15'd0, halted}, 16'h0000);
        checkOutput("unhalt.addr", imem_addr, 16'h0003);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkIfId("unhalt.fetch", 16'h1003, 16'h0004, 1'b1);

        // Redirect collides with data hazard; redirect to 0xFFFF then wrap
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF);
        tick();
        checkOutput("collide.addr", imem_addr, 16'hFFFF);
        checkOutput("collide.valid", {15'd0, valid_out}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkIfId("wrap", 16'h1FFF, 16'h0000, 1'b1);
        checkOutput("wrap.addr", imem_addr, 16'h0000);
        tick();
        checkIfId("wrap.next", 16'h1234, 16'h0001, 1'b1);

        // Reset while halted, with a control hazard also asserted
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h000A);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        checkOutput("halt2.halted", {15'd0, halted}, 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        checkOutput("rst_halt.addr", imem_addr, 16'h0000);
        checkOutput("rst_halt.halted", {15'd0, halted}, 16'h0000);
        checkOutput("rst_halt.valid", {15'd0, valid_out}, 16'h0000);
`ifdef IF_PERF_CNT_EN
        checkOutput("cnt.rst", fetch_stall_cnt, 16'h0000);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkIfId("post_rst", 16'h1234, 16'h0001, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
